mem_arbiter: RTL and testbench

Two-master, one-slave round-robin arbiter for the SoC native memory bus (valid/ready, 32-bit address/data, 4-bit write strobe). It lets a second requester, such as a DMA engine or debug port, share the memory/IO bus with the CPU. It sits between the masters and the memory/IO decode logic. Grants are registered, each transfer is forwarded unchanged, and the optional timeout watchdog completes transfers that the slave never answers.

---
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: native memory bus, valid/ready handshake,
// 32-bit address/data and 4-bit write strobe (0 = read).
interface mem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for the native memory bus.
// Define MEM_ARB_TIMEOUT_EN to add the unanswered-transfer watchdog.
module mem_arbiter
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
)
`endif
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   sel;
    logic   req;
    logic   done;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        expire;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel      = (state_q == GNT1);
        req      = sel ? m1.valid : m0.valid;
        done     = 1'b0;
        s.valid  = 1'b0;
        s.addr   = '0;
        s.wdata  = '0;
        s.wstrb  = '0;
        m0.ready = 1'b0;
        m1.ready = 1'b0;
        m0.rdata = '0;
        m1.rdata = '0;
        timeout  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d    = '0;
        expire   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins
                if (m0.valid && (!m1.valid || last_q))
                    state_d = GNT0;
                else if (m1.valid)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                s.addr   = sel ? m1.addr  : m0.addr;
                s.wdata  = sel ? m1.wdata : m0.wdata;
                s.wstrb  = sel ? m1.wstrb : m0.wstrb;
                s.valid  = req;
                m0.rdata = s.rdata;
                m1.rdata = s.rdata;
                done     = req && s.ready;
`ifdef MEM_ARB_TIMEOUT_EN
                expire = req && !s.ready &&
                         (cnt_q == 16'(TIMEOUT_CYCLES));
                cnt_d  = cnt_q + 16'd1;
                if (expire) begin
                    s.valid = 1'b0;
                    timeout = 1'b1;
                    done    = 1'b1;
                    if (sel)
                        m1.rdata = TIMEOUT_RDATA;
                    else
                        m0.rdata = TIMEOUT_RDATA;
                end
`endif
                m0.ready = done && !sel;
                m1.ready = done && sel;
                if (done) begin
                    state_d = IDLE;
                    last_d  = sel;
                end else if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a transaction-level round-robin model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout;

    always #5 clk = ~clk;

    mem_arbiter_if m0 ();
    mem_arbiter_if m1 ();
    mem_arbiter_if s ();

    localparam int TOC = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    mem_arbiter #(.TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s),
        .timeout(timeout)
    );
`else
    localparam bit TO_EN = 1'b0;
    mem_arbiter dut (
        .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s),
        .timeout(timeout)
    );
`endif

    logic        mv_d [2];
    logic [31:0] ma_d [2];
    logic [31:0] mw_d [2];
    logic [3:0]  ms_d [2];

    assign m0.valid = mv_d[0];
    assign m0.addr  = ma_d[0];
    assign m0.wdata = mw_d[0];
    assign m0.wstrb = ms_d[0];
    assign m1.valid = mv_d[1];
    assign m1.addr  = ma_d[1];
    assign m1.wdata = mw_d[1];
    assign m1.wstrb = ms_d[1];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chkb(input string name, input logic got,
                        input logic exp);
        chk(name, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] st);
        mv_d[i] = 1'b1;
        ma_d[i] = a;
        mw_d[i] = w;
        ms_d[i] = st;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b1;
        mv_d[0] = 1'b0;
        mv_d[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Slave: 0 = never answers, 1 = fixed latency, 2 = random
    int          slave_mode = 0;
    int          slave_lat  = 1;
    logic [31:0] slave_data = '0;
    int          swait      = 0;

    always @(posedge clk) begin
        #2;
        case (slave_mode)
            1: s.ready = s.valid && (swait >= slave_lat);
            2: s.ready = ($urandom % 3) == 0;
            default: s.ready = 1'b0;
        endcase
        s.rdata = (slave_mode == 2) ? $urandom : slave_data;
    end

    always @(negedge clk)
        swait = (s.valid && !s.ready) ? swait + 1 : 0;

    // Transaction-level model: owner of the bus (-1 none),
    // master served last, cycles the current owner has waited.
    int   own    = -1;
    int   lst    = 1;
    int   wc     = 0;
    bit   chk_en = 0;
    logic        mv [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        rdy [2];
    logic        v, esv, eto;
    logic [31:0] ea, ew;
    logic [3:0]  es;

    always @(negedge clk) if (chk_en) begin
        mv[0] = m0.valid; ma[0] = m0.addr;
        mw[0] = m0.wdata; ms[0] = m0.wstrb;
        mv[1] = m1.valid; ma[1] = m1.addr;
        mw[1] = m1.wdata; ms[1] = m1.wstrb;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        esv = 1'b0; eto = 1'b0;
        ea = '0; ew = '0; es = '0;
        if (own >= 0) begin
            v   = mv[own];
            eto = TO_EN && v && !s.ready && (wc == TOC);
            esv = v && !eto;
            ea  = ma[own];
            ew  = mw[own];
            es  = ms[own];
            rdy[own] = v && (s.ready || eto);
        end
        chkb("s_valid", s.valid, esv);
        chk("s_addr", s.addr, ea);
        chk("s_wdata", s.wdata, ew);
        chk("s_wstrb", {28'b0, s.wstrb}, {28'b0, es});
        chkb("m0_ready", m0.ready, rdy[0]);
        chkb("m1_ready", m1.ready, rdy[1]);
        chkb("timeout", timeout, eto);
        if (rdy[0])
            chk("m0_rdata", m0.rdata, eto ? 32'hFFFF_FFFF : s.rdata);
        if (rdy[1])
            chk("m1_rdata", m1.rdata, eto ? 32'hFFFF_FFFF : s.rdata);
        if (rst) begin
            own = -1; lst = 1; wc = 0;
        end else if (own < 0) begin
            wc = 0;
            if (mv[0] && mv[1]) own = (lst == 1) ? 0 : 1;
            else if (mv[0]) own = 0;
            else if (mv[1]) own = 1;
        end else if (!mv[own] || rdy[own]) begin
            if (rdy[own]) lst = own;
            own = -1;
        end else begin
            wc++;
        end
    end

    int   seen, pulses, m0p, done_n, ngr, idle_run, owner, first;
    int   nrdy, nto;
    logic prev_sv;
    logic rg [2];

    initial begin
        mv_d[0] = 1'b0; ma_d[0] = '0; mw_d[0] = '0; ms_d[0] = '0;
        mv_d[1] = 1'b0; ma_d[1] = '0; mw_d[1] = '0; ms_d[1] = '0;
        s.ready = 1'b0;
        s.rdata = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chkb("rst_svalid", s.valid, 1'b0);
        chkb("rst_m0_ready", m0.ready, 1'b0);
        chkb("rst_timeout", timeout, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single m0 read, 1-cycle slave
        slave_mode = 1; slave_lat = 1; slave_data = 32'h1234_5678;
        set_req(0, 32'h0000_0100, 32'h0, 4'h0);
        @(negedge clk);
        chkb("t1_idle_svalid", s.valid, 1'b0);
        @(negedge clk);
        chkb("t1_gnt_svalid", s.valid, 1'b1);
        chkb("t1_early_ready", m0.ready, 1'b0);
        @(negedge clk);
        chkb("t1_m0_ready", m0.ready, 1'b1);
        chk("t1_rdata", m0.rdata, 32'h1234_5678);
        chkb("t1_m1_ready", m1.ready, 1'b0);
        @(posedge clk); #1;
        mv_d[0] = 1'b0;
        @(negedge clk);
        chkb("t1_single_pulse", m0.ready, 1'b0);

        // m1 write
        @(posedge clk); #1;
        set_req(1, 32'h0200_0000, 32'h0000_00A5, 4'hF);
        seen = 0; pulses = 0; m0p = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0.ready) m0p++;
            if (s.valid && seen == 0) begin
                seen = 1;
                chk("t2_addr", s.addr, 32'h0200_0000);
                chk("t2_wdata", s.wdata, 32'h0000_00A5);
                chk("t2_wstrb", {28'b0, s.wstrb}, 32'hF);
            end
            if (m1.ready) begin
                pulses++;
                @(posedge clk); #1;
                mv_d[1] = 1'b0;
            end
        end
        chk("t2_seen", seen, 1);
        chk("t2_pulses", pulses, 1);
        chk("t2_m0_ready", m0p, 0);

        // Both masters continuously, 6 transfers from reset
        reset_pulse();
        set_req(0, 32'h0000_00A0, 32'h1, 4'h0);
        set_req(1, 32'h0000_00B0, 32'h2, 4'h0);
        done_n = 0; ngr = 0; idle_run = 0; prev_sv = 1'b0;
        for (int i = 0; i < 60 && done_n < 6; i++) begin
            @(negedge clk);
            if (!s.valid) begin
                idle_run++;
            end else begin
                if (!prev_sv) begin
                    if (ngr > 0) chk("t3_gap", idle_run, 1);
                    owner = (s.addr == 32'h0000_00B0) ? 1 : 0;
                    chk("t3_order", owner, ngr % 2);
                    ngr++;
                end
                idle_run = 0;
            end
            if (m0.ready || m1.ready) done_n++;
            prev_sv = s.valid;
        end
        chk("t3_transfers", done_n, 6);
        @(posedge clk); #1;
        mv_d[0] = 1'b0;
        mv_d[1] = 1'b0;

        // m0 aborts mid-grant, next tie still goes to m0
        reset_pulse();
        slave_mode = 0;
        set_req(0, 32'h0000_00C0, 32'h3, 4'h1);
        @(negedge clk);
        @(negedge clk);
        chkb("t4_gnt", s.valid, 1'b1);
        @(posedge clk); #1;
        mv_d[0] = 1'b0;
        @(negedge clk);
        chkb("t4_abort_svalid", s.valid, 1'b0);
        chkb("t4_abort_ready", m0.ready, 1'b0);
        @(posedge clk); #1;
        set_req(0, 32'h0000_00C0, 32'h3, 4'h1);
        set_req(1, 32'h0000_00D0, 32'h4, 4'h2);
        @(negedge clk);
        chkb("t4_idle", s.valid, 1'b0);
        @(negedge clk);
        chkb("t4_tie_valid", s.valid, 1'b1);
        chk("t4_tie_m0", s.addr, 32'h0000_00C0);

        // Reset mid-transfer in GNT1
        reset_pulse();
        set_req(1, 32'h0000_00E0, 32'h5, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chkb("t5_gnt1", s.valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 32'h0000_00F0, 32'h6, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chkb("t5_svalid", s.valid, 1'b0);
        chkb("t5_m1_ready", m1.ready, 1'b0);
        @(negedge clk);
        chkb("t5_tie_valid", s.valid, 1'b1);
        chk("t5_tie_m0", s.addr, 32'h0000_00F0);

        // Unanswered transfer
        reset_pulse();
        set_req(0, 32'h0000_0044, 32'h7, 4'h0);
        first = -1; nrdy = 0; nto = 0;
        for (int i = 0; i <= 100 && first < 0; i++) begin
            @(negedge clk);
            if (timeout) nto++;
            if (m0.ready) begin
                nrdy++;
                first = i;
                chkb("t6_timeout", timeout, 1'b1);
                chk("t6_rdata", m0.rdata, 32'hFFFF_FFFF);
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t6_ready_cycle", first, 5);
`else
        chk("t6_no_ready", nrdy, 0);
        chk("t6_no_timeout", nto, 0);
`endif
        @(posedge clk); #1;
        mv_d[0] = 1'b0;

        // Randomized traffic
        reset_pulse();
        slave_mode = 2;
        rg[0] = 1'b0;
        rg[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rg[0] = m0.ready;
            rg[1] = m1.ready;
            @(posedge clk); #1;
            rst = (($urandom % 400) == 0);
            for (int i = 0; i < 2; i++) begin
                if (mv_d[i] && !rg[i]) begin
                    if (($urandom % 50) == 0) mv_d[i] = 1'b0;
                end else if (mv_d[i]) begin
                    if ($urandom % 2) mv_d[i] = 1'b0;
                    else set_req(i, $urandom, $urandom, 4'($urandom));
                end else if ($urandom % 2) begin
                    set_req(i, $urandom, $urandom, 4'($urandom));
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mv_d[0] = 1'b0;
        mv_d[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
